// File: rtl/uart_rx_os_pkg.sv
// uart_rx_os_pkg: shared receiver state encoding and default frame constants
package uart_rx_os_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;
  localparam int UART_OS = 16;
  localparam int UART_DBIT = 8;
endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: oversample strobe, serial line and received-word status bundle
interface uart_rx_os_if import uart_rx_os_pkg::*; #(
  parameter int DBIT = UART_DBIT
);
  logic s_tick;
  logic rx;
  logic [DBIT-1:0] dout;
  logic rx_done_tick;
  logic parity_err;
  logic frame_err;
  logic busy;
  modport master (output s_tick, rx, input dout, rx_done_tick, parity_err, frame_err, busy);
  modport slave (input s_tick, rx, output dout, rx_done_tick, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_os_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= {2{RST_VAL}};
    else s_q <= {s_q[0], d_i};
  end
  assign q_o = s_q[1];
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with parity and framing status
module uart_rx_os import uart_rx_os_pkg::*; #(
  parameter int DBIT       = UART_DBIT,
  parameter int OS         = UART_OS,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clk,
  input logic rst,
  uart_rx_os_if.slave u
);
  localparam int SCW = $clog2(OS * 2);
  localparam int NW = $clog2(DBIT);
  localparam logic [SCW-1:0] HALF = SCW'(OS / 2 - 1);
  localparam logic [SCW-1:0] FULL = SCW'(OS - 1);
  localparam logic [SCW-1:0] SBT = SCW'(SB_TICK - 1);
  localparam logic [NW-1:0] LASTN = NW'(DBIT - 1);
  uart_rx_state_t state_q, state_d;
  logic [SCW-1:0] s_cnt_q, s_cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [DBIT-1:0] b_q, b_d, dout_q, dout_d;
  logic p_q, p_d, done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
  logic rx_s, tick;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d_i(u.rx), .q_o(rx_s));
  assign tick = u.s_tick;
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d = n_q;
    b_d = b_q;
    p_d = p_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        s_cnt_d = '0;
      end
      START: if (tick) begin
        if (s_cnt_q == HALF) begin
          state_d = rx_s ? IDLE : DATA;
          s_cnt_d = '0;
          n_d = '0;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      DATA: if (tick) begin
        if (s_cnt_q == FULL) begin
          s_cnt_d = '0;
          b_d = {rx_s, b_q[DBIT-1:1]};
          if (n_q == LASTN) state_d = PARITY_EN ? PARITY : STOP;
          else n_d = n_q + 1'b1;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      PARITY: if (tick) begin
        if (s_cnt_q == FULL) begin
          s_cnt_d = '0;
          p_d = rx_s;
          state_d = STOP;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      STOP: if (tick) begin
        if (s_cnt_q == SBT) begin
          done_d = 1'b1;
          s_cnt_d = '0;
          state_d = rx_s ? IDLE : BREAK;
        end else s_cnt_d = s_cnt_q + 1'b1;
      end
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dout_d = done_d ? b_q : dout_q;
    ferr_d = done_d ? ~rx_s : ferr_q;
    perr_d = done_d ? (PARITY_EN & (^b_q ^ p_q ^ PARITY_ODD)) : perr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_q <= '0;
      b_q <= '0;
      p_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q <= n_d;
      b_q <= b_d;
      p_q <= p_d;
      done_q <= done_d;
      dout_q <= dout_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end
  assign u.dout = dout_q;
  assign u.rx_done_tick = done_q;
  assign u.parity_err = perr_q;
  assign u.frame_err = ferr_q;
  assign u.busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frame vectors plus glitch, break, reset and back-to-back sequences
module tb_uart_rx_os;
  typedef struct {
    logic       sel;
    logic [7:0] d;
    logic       pbit;
    logic [7:0] exp_dout;
    logic       exp_perr;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, rx_line = 1'b1, sel = 1'b0;
  int cyc = 0, n_tests = 0, n_fail = 0, cnt_a = 0, cnt_b = 0;
  int tq[$];
  logic [7:0] dq[$];
  vec_t v[9];
  uart_rx_os_if #(.DBIT(8)) ifa ();
  uart_rx_os_if #(.DBIT(8)) ifb ();
  assign ifa.s_tick = tick;
  assign ifb.s_tick = tick;
  assign ifa.rx = sel ? 1'b1 : rx_line;
  assign ifb.rx = sel ? rx_line : 1'b1;
  uart_rx_os #(.DBIT(8), .OS(16), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut_a (.clk(clk), .rst(rst), .u(ifa));
  uart_rx_os #(.DBIT(8), .OS(16), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    dut_b (.clk(clk), .rst(rst), .u(ifb));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    tick = ~tick;
  end
  always @(negedge clk) begin
    if (ifa.rx_done_tick) begin
      cnt_a <= cnt_a + 1;
      tq.push_back(cyc);
      dq.push_back(ifa.dout);
    end
    if (ifb.rx_done_tick) cnt_b <= cnt_b + 1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic hold(input logic val, input int n);
    rx_line = val;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic par, input logic pbit, input logic stop);
    hold(1'b0, 32);
    for (int i = 0; i < 8; i++) hold(d[i], 32);
    if (par) hold(pbit, 32);
    hold(stop, 32);
  endtask
  initial begin
    int c0;
    v[0] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    v[1] = '{1'b0, 8'h81, 1'b0, 8'h81, 1'b0};
    v[2] = '{1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0};
    v[3] = '{1'b1, 8'h37, 1'b0, 8'h37, 1'b1};
    v[4] = '{1'b1, 8'h37, 1'b1, 8'h37, 1'b0};
    v[5] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0};
    v[6] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1};
    v[7] = '{1'b1, 8'h01, 1'b1, 8'h01, 1'b0};
    v[8] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
    hold(1'b1, 5);
    chk("rst_busy_a", ifa.busy, 0);
    chk("rst_dout_a", ifa.dout, 0);
    chk("rst_done_a", ifa.rx_done_tick, 0);
    chk("rst_errs_b", {ifb.parity_err, ifb.frame_err, ifb.busy}, 0);
    rst = 1'b0;
    hold(1'b1, 8);
    foreach (v[i]) begin
      sel = v[i].sel;
      hold(1'b1, 8);
      c0 = sel ? cnt_b : cnt_a;
      send(v[i].d, sel, v[i].pbit, 1'b1);
      hold(1'b1, 16);
      chk($sformatf("v%0d_done", i), (sel ? cnt_b : cnt_a) - c0, 1);
      chk($sformatf("v%0d_dout", i), sel ? ifb.dout : ifa.dout, v[i].exp_dout);
      chk($sformatf("v%0d_perr", i), sel ? ifb.parity_err : ifa.parity_err, v[i].exp_perr);
      chk($sformatf("v%0d_ferr", i), sel ? ifb.frame_err : ifa.frame_err, 0);
      chk($sformatf("v%0d_busy", i), sel ? ifb.busy : ifa.busy, 0);
    end
    sel = 1'b0;
    hold(1'b1, 8);
    c0 = cnt_a;
    hold(1'b0, 10);
    chk("glitch_busy_hi", ifa.busy, 1);
    hold(1'b1, 16);
    chk("glitch_busy_lo", ifa.busy, 0);
    chk("glitch_no_done", cnt_a - c0, 0);
    c0 = cnt_a;
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 96);
    chk("brk_done", cnt_a - c0, 1);
    chk("brk_dout", ifa.dout, 8'h5A);
    chk("brk_ferr", ifa.frame_err, 1);
    chk("brk_busy", ifa.busy, 1);
    hold(1'b1, 32);
    chk("brk_exit", ifa.busy, 0);
    chk("brk_single", cnt_a - c0, 1);
    send(8'h81, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 16);
    chk("brk_after_dout", ifa.dout, 8'h81);
    chk("brk_after_ferr", ifa.frame_err, 0);
    chk("brk_after_done", cnt_a - c0, 2);
    hold(1'b0, 32);
    for (int i = 0; i < 4; i++) hold(1'(8'h3C >> i), 32);
    hold(1'b1, 16);
    chk("mid_busy_pre", ifa.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_outs", {ifa.dout, ifa.rx_done_tick, ifa.parity_err, ifa.frame_err}, 0);
    hold(1'b1, 4);
    rst = 1'b0;
    hold(1'b1, 8);
    c0 = cnt_a;
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 16);
    chk("post_rst_dout", ifa.dout, 8'h3C);
    chk("post_rst_done", cnt_a - c0, 1);
    hold(1'b1, 8);
    tq.delete();
    dq.delete();
    send(8'h00, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 32);
    chk("b2b_count", tq.size(), 2);
    if (tq.size() == 2) begin
      chk("b2b_first", dq[0], 8'h00);
      chk("b2b_second", dq[1], 8'hFF);
      chk("b2b_spacing", tq[1] - tq[0], 320);
    end
    chk("b2b_busy", ifa.busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
